noc3_node: RTL and testbench

- Single-clock network-interface node bridging a local 64-bit word port to an AXI4 slave port (128-bit data, 4-bit ID).
- Local agent pushes tagged request words into a request FIFO; AXI master drains them with read bursts.
- AXI master pushes tagged response words through write bursts into a response FIFO, which the local agent pops.
- Carries a reserved serial debug pair (rxd/txd).

---
 rtl/noc3_pkg.sv | 37 +++
 rtl/noc3_if.sv | 69 ++++++
 rtl/noc3_fifo.sv | 65 ++++++
 rtl/noc3_node.sv | 226 ++++++++++++++++++++++
 tb/tb_noc3_node.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc3_pkg.sv
// Shared types and constants for the noc3 network-interface node.
package noc3_pkg;

    localparam int AXI_DW   = 128;
    localparam int AXI_IDW  = 4;
    localparam int AXI_AW   = 32;
    localparam int LOCAL_DW = 64;
    localparam int TAGW     = 3;
    localparam int CNT_W    = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [TAGW-1:0]     tag;
        logic [LOCAL_DW-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // Read beat layout: zero pad, valid flag, then the raw FIFO entry.
    function automatic logic [AXI_DW-1:0] pack_beat(input logic valid, input entry_t e);
        return valid ? {{(AXI_DW-ENTRY_W-1){1'b0}}, 1'b1, e} : '0;
    endfunction

endpackage

// File: rtl/noc3_if.sv
// AXI4 bus between an external master and the noc3 node slave port.
interface noc3_if;
    import noc3_pkg::*;

    logic [AXI_IDW-1:0]  awid;
    logic [AXI_AW-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [AXI_DW-1:0]   wdata;
    logic [AXI_DW/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [AXI_IDW-1:0]  bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [AXI_IDW-1:0]  arid;
    logic [AXI_AW-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [AXI_IDW-1:0]  rid;
    logic [AXI_DW-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/noc3_fifo.sv
// Show-ahead FIFO with registered occupancy; a push into a full FIFO only
// lands when a pop frees a slot in the same cycle.
module noc3_fifo
    import noc3_pkg::*;
#(
    parameter int W     = 67,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [W-1:0]     din_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 8'd1;
            2'b01:   count_d = count_q - 8'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage is left out of reset so it can map onto RAM; flushing is
    // done by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/noc3_node.sv
// Network-interface node: local request words leave through AXI read bursts,
// AXI write bursts fill the tagged response FIFO popped by the local agent.
module noc3_node
    import noc3_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TAGW  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [TAGW-1:0]     req_addr_i,
    input  logic [LOCAL_DW-1:0] req_data_i,
    input  logic                req_write_i,
    output logic [CNT_W-1:0]    req_count_o,
    input  logic [TAGW-1:0]     resp_addr_i,
    input  logic                resp_read_i,
    output logic [LOCAL_DW-1:0] resp_data_o,
    output logic [CNT_W-1:0]    resp_count_o,
    noc3_if.slave               axi,
    input  logic                rxd_i,
    output logic                txd_o
);

    entry_t req_din;
    entry_t req_head;
    entry_t resp_din;
    entry_t resp_head;
    logic   req_empty;
    logic   req_full;
    logic   req_pop;
    logic   resp_empty;
    logic   resp_full;
    logic   resp_push;
    logic   resp_pop;

    assign req_din = {req_addr_i, req_data_i};

    noc3_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_write_i),
        .din_i   (req_din),
        .pop_i   (req_pop),
        .head_o  (req_head),
        .empty_o (req_empty),
        .full_o  (req_full),
        .count_o (req_count_o)
    );

    noc3_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (resp_push),
        .din_i   (resp_din),
        .pop_i   (resp_pop),
        .head_o  (resp_head),
        .empty_o (resp_empty),
        .full_o  (resp_full),
        .count_o (resp_count_o)
    );

    // The local agent only consumes the head when it names the head's tag.
    assign resp_pop    = resp_read_i && !resp_empty && (resp_head.tag == resp_addr_i);
    assign resp_data_o = resp_empty ? '0 : resp_head.data;
    assign txd_o       = 1'b1;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_e           w_state_q;
    logic               awready_q;
    logic               bvalid_q;
    logic [AXI_IDW-1:0] bid_q;
    logic [1:0]         bresp_q;
    logic [7:0]         w_len_q;
    logic [7:0]         w_beat_q;
    logic [TAGW-1:0]    w_tag_q;
    logic               w_err_q;
    logic               w_err_d;
    logic               wready;
    logic               w_accept;
    logic               w_beat_ok;

    assign wready    = (w_state_q == W_DATA) && !resp_full;
    assign w_accept  = wready && axi.wvalid;
    assign w_beat_ok = (axi.wstrb[7:0] == 8'hFF);
    assign resp_push = w_accept && w_beat_ok;
    assign w_err_d   = w_err_q || (w_accept && !w_beat_ok);
    assign resp_din  = {w_tag_q, axi.wdata[LOCAL_DW-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_tag_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            unique case (w_state_q)
                W_IDLE: begin
                    if (awready_q && axi.awvalid) begin
                        awready_q <= 1'b0;
                        bid_q     <= axi.awid;
                        w_len_q   <= axi.awlen;
                        w_tag_q   <= axi.awaddr[4 +: TAGW];
                        w_beat_q  <= '0;
                        w_err_q   <= 1'b0;
                        w_state_q <= W_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    // Beat count, not wlast, decides where the burst ends.
                    if (w_accept) begin
                        w_err_q <= w_err_d;
                        if (w_beat_q == w_len_q) begin
                            bvalid_q  <= 1'b1;
                            bresp_q   <= w_err_d ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end else begin
                            w_beat_q <= w_beat_q + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        bvalid_q  <= 1'b0;
                        w_err_q   <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready;
    assign axi.bvalid  = bvalid_q;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_e           r_state_q;
    logic               arready_q;
    logic               rvalid_q;
    logic [AXI_IDW-1:0] rid_q;
    logic [7:0]         r_len_q;
    logic [7:0]         r_beat_q;
    logic               r_fresh_q;
    logic [AXI_DW-1:0]  r_hold_q;
    logic [AXI_DW-1:0]  r_live;
    logic [AXI_DW-1:0]  r_beat_data;

    // A beat shows the live head on its first cycle, then is frozen in
    // r_hold_q so a late push cannot change it while the master stalls.
    assign r_live      = pack_beat(!req_empty, req_head);
    assign r_beat_data = r_fresh_q ? r_live : r_hold_q;
    assign req_pop     = rvalid_q && axi.rready && r_beat_data[ENTRY_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_fresh_q <= 1'b0;
            r_hold_q  <= '0;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (arready_q && axi.arvalid) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rid_q     <= axi.arid;
                        r_len_q   <= axi.arlen;
                        r_beat_q  <= '0;
                        r_fresh_q <= 1'b1;
                        r_state_q <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (axi.rready) begin
                        if (r_beat_q == r_len_q) begin
                            rvalid_q  <= 1'b0;
                            r_fresh_q <= 1'b0;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_beat_q  <= r_beat_q + 8'd1;
                            r_fresh_q <= 1'b1;
                        end
                    end else if (r_fresh_q) begin
                        r_hold_q  <= r_live;
                        r_fresh_q <= 1'b0;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rid     = rid_q;
    assign axi.rresp   = RESP_OKAY;
    assign axi.rlast   = rvalid_q && (r_beat_q == r_len_q);
    assign axi.rdata   = rvalid_q ? r_beat_data : '0;

    logic unused_ok;
    assign unused_ok = ^{rxd_i, req_full, axi.awaddr[31:7], axi.awaddr[3:0],
                         axi.awsize, axi.awburst, axi.awcache, axi.awprot,
                         axi.wdata[AXI_DW-1:LOCAL_DW], axi.wstrb[15:8], axi.wlast,
                         axi.araddr, axi.arsize, axi.arburst, axi.arcache, axi.arprot};

endmodule

// File: tb/tb_noc3_node.sv
// Randomised self-checking bench for noc3_node against queue-based FIFO models.
module tb_noc3_node;
    import noc3_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_addr;
    logic [63:0] req_data;
    logic        req_write;
    logic [7:0]  req_count;
    logic [2:0]  resp_addr;
    logic        resp_read;
    logic [63:0] resp_data;
    logic [7:0]  resp_count;
    logic        rxd;
    logic        txd;

    noc3_if axi ();

    noc3_node #(.DEPTH(DEPTH), .TAGW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .req_write_i  (req_write),
        .req_count_o  (req_count),
        .resp_addr_i  (resp_addr),
        .resp_read_i  (resp_read),
        .resp_data_o  (resp_data),
        .resp_count_o (resp_count),
        .axi          (axi),
        .rxd_i        (rxd),
        .txd_o        (txd)
    );

    always #5 clk = ~clk;

    // Reference model: each FIFO is simply an ordered list of {tag, data}.
    logic [66:0] req_m[$];
    logic [66:0] resp_m[$];
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [2:0] t, input logic [63:0] d);
        req_addr  = t;
        req_data  = d;
        req_write = 1'b1;
        tick();
        req_write = 1'b0;
        if (req_m.size() < DEPTH) req_m.push_back({t, d});
        $display("push_req tag=%0d data=%0h count=%0d", t, d, req_count);
        check("req_count", req_count, req_m.size());
    endtask

    task automatic pop_resp(input logic [2:0] a);
        bit hit;
        hit = (resp_m.size() > 0) && (resp_m[0][66:64] == a);
        check("resp_data", resp_data, (resp_m.size() > 0) ? resp_m[0][63:0] : 64'h0);
        resp_addr = a;
        resp_read = 1'b1;
        tick();
        resp_read = 1'b0;
        if (hit) void'(resp_m.pop_front());
        $display("pop_resp tag=%0d hit=%0d count=%0d", a, hit, resp_count);
        check("resp_count", resp_count, resp_m.size());
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [7:0] len, input bit stall,
                            input bit push_first, input logic [66:0] pw);
        int n;
        int st;
        bit pv;
        logic [127:0] exp;
        axi.arid    = id;
        axi.arlen   = len;
        axi.araddr  = $urandom;
        axi.arsize  = 3'($urandom);
        axi.arvalid = 1'b1;
        n = 0;
        while (axi.arready !== 1'b1 && n < 20) begin tick(); n++; end
        check("arready", axi.arready, 1);
        tick();
        axi.arvalid = 1'b0;
        n = 0;
        while (axi.rvalid !== 1'b1 && n < 8) begin tick(); n++; end
        for (int b = 0; b <= int'(len); b++) begin
            pv  = req_m.size() > 0;
            exp = pv ? {60'b0, 1'b1, req_m[0]} : 128'h0;
            st  = stall ? $urandom_range(0, 2) : 0;
            for (int s = 0; s < st; s++) begin
                check("rdata_hold", axi.rdata, exp);
                if (!pv && $urandom_range(0, 1) == 1) begin
                    req_addr  = 3'($urandom);
                    req_data  = {$urandom, $urandom};
                    req_write = 1'b1;
                end
                tick();
                if (req_write) begin
                    if (req_m.size() < DEPTH) req_m.push_back({req_addr, req_data});
                    req_write = 1'b0;
                end
            end
            check("rvalid", axi.rvalid, 1);
            check("rdata", axi.rdata, exp);
            check("rlast", axi.rlast, b == int'(len));
            check("rid", axi.rid, id);
            check("rresp", axi.rresp, 2'b00);
            axi.rready = 1'b1;
            if (push_first && b == 0) begin
                req_addr  = pw[66:64];
                req_data  = pw[63:0];
                req_write = 1'b1;
            end
            tick();
            axi.rready = 1'b0;
            if (pv) void'(req_m.pop_front());
            if (req_write) begin
                if (req_m.size() < DEPTH) req_m.push_back({req_addr, req_data});
                req_write = 1'b0;
            end
            $display("read id=%0d beat=%0d valid=%0d req_count=%0d", id, b, pv, req_count);
            check("req_count_rd", req_count, req_m.size());
        end
        check("rvalid_end", axi.rvalid, 0);
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [63:0] base, input bit rnd, input logic [15:0] strb,
                             input bit pop_on_stall);
        int n;
        bit err;
        bit accepted;
        logic [63:0] d;
        logic [15:0] s;
        axi.awid    = id;
        axi.awaddr  = addr;
        axi.awlen   = len;
        axi.awburst = 2'($urandom);
        axi.awvalid = 1'b1;
        n = 0;
        while (axi.awready !== 1'b1 && n < 20) begin tick(); n++; end
        check("awready", axi.awready, 1);
        tick();
        axi.awvalid = 1'b0;
        err = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            d = rnd ? {$urandom, $urandom} : base + 64'(b);
            s = rnd ? (($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF) : strb;
            axi.wdata  = {$urandom, $urandom, d};
            axi.wstrb  = s;
            axi.wlast  = (b == int'(len));
            axi.wvalid = 1'b1;
            accepted = 1'b0;
            n = 0;
            while (!accepted && n < 50) begin
                check("wready", axi.wready, resp_m.size() < DEPTH);
                if (axi.wready === 1'b1) begin
                    tick();
                    accepted = 1'b1;
                end else if (pop_on_stall && resp_m.size() > 0) begin
                    pop_resp(resp_m[0][66:64]);
                end else begin
                    tick();
                end
                n++;
            end
            if (!accepted) check("w_timeout", 0, 1);
            if (accepted) begin
                if (s[7:0] == 8'hFF) begin
                    if (resp_m.size() < DEPTH) resp_m.push_back({addr[6:4], d});
                end else begin
                    err = 1'b1;
                end
            end
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        n = 0;
        while (axi.bvalid !== 1'b1 && n < 8) begin tick(); n++; end
        check("bvalid", axi.bvalid, 1);
        check("bid", axi.bid, id);
        check("bresp", axi.bresp, err ? 2'b10 : 2'b00);
        $display("write id=%0d len=%0d bresp=%0d resp_count=%0d", id, len, axi.bresp, resp_count);
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
        check("bvalid_end", axi.bvalid, 0);
        check("resp_count_wr", resp_count, resp_m.size());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        req_addr = '0; req_data = '0; req_write = 1'b0;
        resp_addr = '0; resp_read = 1'b0; rxd = 1'b0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.awcache = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
        axi.arcache = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

        repeat (3) tick();
        check("rst_awready", axi.awready, 0);
        check("rst_wready", axi.wready, 0);
        check("rst_bvalid", axi.bvalid, 0);
        check("rst_arready", axi.arready, 0);
        check("rst_rvalid", axi.rvalid, 0);
        check("rst_rlast", axi.rlast, 0);
        check("rst_ids", {axi.bid, axi.rid, axi.bresp, axi.rresp}, 0);
        check("rst_rdata", axi.rdata, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_counts", {req_count, resp_count}, 0);
        check("rst_txd", txd, 1);
        rst = 1'b0;
        tick();
        check("post_rst_awready", axi.awready, 1);
        check("post_rst_arready", axi.arready, 1);

        // Three tagged words drained by a 4-beat read; the last beat is empty.
        push_req(3'd1, 64'h11);
        push_req(3'd2, 64'h22);
        push_req(3'd3, 64'h33);
        axi_read(4'd5, 8'd3, 1'b0, 1'b0, '0);

        // Two-beat write tagged 2, then tag-filtered pops.
        axi_write(4'd3, 32'h20, 8'd1, 64'hA, 1'b0, 16'hFFFF, 1'b0);
        pop_resp(3'd3);
        pop_resp(3'd2);
        pop_resp(3'd2);

        // 18-beat write against a 16-deep response FIFO.
        axi_write(4'd1, 32'h50, 8'd17, 64'h100, 1'b0, 16'hFFFF, 1'b1);
        n = 0;
        while (resp_m.size() > 0 && n < 40) begin pop_resp(resp_m[0][66:64]); n++; end

        // Partial strobe drops the beat and flags SLVERR; next burst is clean.
        axi_write(4'd2, 32'h10, 8'd0, 64'h77, 1'b0, 16'h00F0, 1'b0);
        axi_write(4'd2, 32'h10, 8'd0, 64'h78, 1'b0, 16'hFFFF, 1'b0);
        pop_resp(3'd1);

        // Full request FIFO: push coinciding with a read pop, then drain.
        for (int i = 0; i < DEPTH; i++) push_req(3'($urandom), {$urandom, $urandom});
        axi_read(4'd1, 8'd0, 1'b0, 1'b1, {3'd7, 64'hDEAD_BEEF_0000_0017});
        axi_read(4'd2, 8'd16, 1'b0, 1'b0, '0);

        // Reset in the middle of a read burst.
        push_req(3'd4, 64'h44);
        push_req(3'd5, 64'h55);
        axi_write(4'd6, 32'h30, 8'd0, 64'h66, 1'b0, 16'hFFFF, 1'b0);
        axi.arid = 4'd9; axi.arlen = 8'd3; axi.arvalid = 1'b1;
        n = 0;
        while (axi.rvalid !== 1'b1 && n < 20) begin tick(); n++; end
        axi.arvalid = 1'b0;
        check("mid_rvalid", axi.rvalid, 1);
        rst = 1'b1;
        #1;
        req_m.delete();
        resp_m.delete();
        check("arst_rvalid", axi.rvalid, 0);
        check("arst_counts", {req_count, resp_count}, 0);
        check("arst_rdata", axi.rdata, 0);
        tick();
        rst = 1'b0;
        tick();
        check("rel_arready", axi.arready, 1);
        check("rel_txd", txd, 1);
        check("rel_rvalid", axi.rvalid, 0);

        // Random mix of all four operations.
        repeat (120) begin
            case ($urandom_range(0, 3))
                0: push_req(3'($urandom), {$urandom, $urandom});
                1: axi_read(4'($urandom), 8'($urandom_range(0, 5)), 1'b1, 1'b0, '0);
                2: axi_write(4'($urandom), $urandom, 8'($urandom_range(0, 4)), 64'h0, 1'b1, 16'h0, 1'b1);
                default: begin
                    if (resp_m.size() > 0 && $urandom_range(0, 1) == 1) pop_resp(resp_m[0][66:64]);
                    else pop_resp(3'($urandom));
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
